// File: rtl/tone_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tone_scheduler
// Purpose  : Arbitrates music and sound-effect notes onto a single tone
//            generator. Each accepted note plays for dur ticks, followed by
//            a silent gap of GAP_TICKS ticks. Effects take priority over
//            music and may cut a music note short. Effects are never cut
//            short.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            mus_valid/mus_ready    - music note handshake
//            mus_note, mus_dur      - music note code and length in ticks
//            fx_valid/fx_ready      - effect note handshake
//            fx_note, fx_dur        - effect note code and length in ticks
//            tone_note, tone_en     - registered drive to the tone generator
//            src                    - registered source (0=music, 1=effect)
//            busy                   - registered, high while not idle
// Revision : 1.0 - initial release
// ============================================================================
module tone_scheduler #(
  parameter int TICK_DIV  = 1562500,
  parameter int GAP_TICKS = 2,
  parameter int PREEMPT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mus_valid,
  output logic       mus_ready,
  input  logic [7:0] mus_note,
  input  logic [5:0] mus_dur,
  input  logic       fx_valid,
  output logic       fx_ready,
  input  logic [7:0] fx_note,
  input  logic [5:0] fx_dur,
  output logic [7:0] tone_note,
  output logic       tone_en,
  output logic       src,
  output logic       busy
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]      GAP_LAST   = 6'(GAP_TICKS - 1);
  localparam logic [7:0]      NOTE_MAX   = 8'd95;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [5:0]    dur_q, dur_d;
  logic          src_q, src_d;
  logic [7:0]    tone_note_q, tone_note_d;
  logic          tone_en_q, tone_en_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          fx_acc;
  logic          mus_acc;
  logic [7:0]    new_note;
  logic [5:0]    new_dur;
  logic          new_rest;

  // Effects may interrupt music only; an effect in progress is never cut.
  assign mus_ready = !reset && (state_q == S_IDLE) && !fx_valid;
  assign fx_ready  = !reset &&
                     ((state_q == S_IDLE) ||
                      ((PREEMPT != 0) && (state_q == S_PLAY) && !src_q) ||
                      ((state_q == S_GAP) && !src_q));

  assign fx_acc   = fx_valid && fx_ready;
  assign mus_acc  = mus_valid && mus_ready;
  assign tick     = (presc_q == PRESC_LAST);

  // Effect wins; mus_ready already excludes a simultaneous fx request.
  assign new_note = fx_acc ? fx_note : mus_note;
  assign new_dur  = fx_acc ? fx_dur : mus_dur;
  assign new_rest = (new_note == 8'd0) || (new_note > NOTE_MAX);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    cnt_d       = cnt_q;
    dur_d       = dur_q;
    src_d       = src_q;
    tone_note_d = tone_note_q;
    tone_en_d   = tone_en_q;

    case (state_q)
      S_PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          cnt_d = cnt_q + 6'd1;
          // dur_q is at least 1, so dur_q-1 never underflows.
          if (cnt_q == dur_q - 6'd1) begin
            cnt_d       = 6'd0;
            tone_note_d = 8'd0;
            tone_en_d   = 1'b0;
            state_d     = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == GAP_LAST) begin
            cnt_d   = 6'd0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tone_note_d = 8'd0;
        tone_en_d   = 1'b0;
      end
    endcase

    // A new note (including a preempting effect) restarts timing from zero.
    if (fx_acc || mus_acc) begin
      state_d     = S_PLAY;
      src_d       = fx_acc;
      dur_d       = (new_dur == 6'd0) ? 6'd1 : new_dur;
      presc_d     = '0;
      cnt_d       = 6'd0;
      tone_note_d = new_rest ? 8'd0 : new_note;
      tone_en_d   = !new_rest;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      cnt_q       <= 6'd0;
      dur_q       <= 6'd1;
      src_q       <= 1'b0;
      tone_note_q <= 8'd0;
      tone_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      dur_q       <= dur_d;
      src_q       <= src_d;
      tone_note_q <= tone_note_d;
      tone_en_q   <= tone_en_d;
      busy_q      <= busy_d;
    end
  end

  assign tone_note = tone_note_q;
  assign tone_en   = tone_en_q;
  assign src       = src_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
